// File: rtl/systolic_sequencer_if.sv
// Operand-load / compute-control / array-feed bundle between a host and systolic_sequencer.
// The abort signal exists only when SEQ_ABORT_EN is defined.
interface systolic_sequencer_if #(
    parameter int MATRIX_SIZE = 4,
    parameter int DATA_WIDTH  = 8
);
    localparam int ROW_W = $clog2(MATRIX_SIZE);

    logic                              wr_en;
    logic                              wr_sel;
    logic [ROW_W-1:0]                  wr_row;
    logic [MATRIX_SIZE*DATA_WIDTH-1:0] wr_data;
    logic                              start;
`ifdef SEQ_ABORT_EN
    logic                              abort;
`endif
    logic                              busy;
    logic                              done;
    logic                              result_valid;
    logic                              wr_err;
    logic                              acc_rst;
    logic                              acc_en;
    logic                              shift_en;
    logic [MATRIX_SIZE*DATA_WIDTH-1:0] in_left_flat;
    logic [MATRIX_SIZE*DATA_WIDTH-1:0] in_top_flat;

    modport master (
        output wr_en, wr_sel, wr_row, wr_data, start,
`ifdef SEQ_ABORT_EN
        output abort,
`endif
        input  busy, done, result_valid, wr_err,
        input  acc_rst, acc_en, shift_en, in_left_flat, in_top_flat
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_data, start,
`ifdef SEQ_ABORT_EN
        input  abort,
`endif
        output busy, done, result_valid, wr_err,
        output acc_rst, acc_en, shift_en, in_left_flat, in_top_flat
    );
endinterface

// File: rtl/systolic_sequencer.sv
// Holds one A/B operand tile and drives a skewed feed into an NxN systolic_array.
// Define SEQ_ABORT_EN to add an abort input that cancels a compute in flight.
module systolic_sequencer #(
    parameter int MATRIX_SIZE = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int DRAIN_EXTRA = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    systolic_sequencer_if.slave seq_if
);
    localparam int N     = MATRIX_SIZE;
    localparam int DW    = DATA_WIDTH;
    localparam int ROW_W = $clog2(N);
    localparam int CNT_W = $clog2(3*N + DRAIN_EXTRA) + 1;
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2*N - 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N - 2 + DRAIN_EXTRA);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DW-1:0] a_q [N][N];
    logic [DW-1:0] b_q [N][N];
    logic [DW-1:0] left_q [N];
    logic [DW-1:0] left_d [N];
    logic [DW-1:0] top_q  [N];
    logic [DW-1:0] top_d  [N];

    logic acc_rst_q, acc_rst_d;
    logic acc_en_q,  acc_en_d;
    logic done_q,    done_d;
    logic rv_q,      rv_d;
    logic wr_err_q,  wr_err_d;
    logic idle, accept, abort_req;

    assign idle   = (state_q == S_IDLE);
    assign accept = idle && seq_if.start;

`ifdef SEQ_ABORT_EN
    assign abort_req = seq_if.abort &&
                       ((state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_DRAIN));
`else
    assign abort_req = 1'b0;
`endif

    // Tile store: only written while idle, so a running compute always sees a stable tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int k = 0; k < N; k++) begin
                    a_q[r][k] <= '0;
                    b_q[r][k] <= '0;
                end
            end
        end else if (seq_if.wr_en && idle) begin
            for (int r = 0; r < N; r++) begin
                if (seq_if.wr_row == ROW_W'(r)) begin
                    for (int k = 0; k < N; k++) begin
                        if (seq_if.wr_sel) begin
                            b_q[r][k] <= seq_if.wr_data[k*DW +: DW];
                        end else begin
                            a_q[r][k] <= seq_if.wr_data[k*DW +: DW];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_rst_q <= 1'b0;
            acc_en_q  <= 1'b0;
            done_q    <= 1'b0;
            rv_q      <= 1'b0;
            wr_err_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                left_q[i] <= '0;
                top_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_rst_q <= acc_rst_d;
            acc_en_q  <= acc_en_d;
            done_q    <= done_d;
            rv_q      <= rv_d;
            wr_err_q  <= wr_err_d;
            for (int i = 0; i < N; i++) begin
                left_q[i] <= left_d[i];
                top_q[i]  <= top_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (seq_if.start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort_req) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs are decoded from the next state so the registered values line up with state_q.
    always_comb begin
        logic [CNT_W-1:0] skew_k;
        skew_k    = '0;
        acc_rst_d = (state_d == S_CLEAR);
        acc_en_d  = (state_d == S_FEED) || (state_d == S_DRAIN);
        done_d    = (state_d == S_DONE);
        wr_err_d  = seq_if.wr_en && !idle;
        rv_d      = rv_q;
        if (accept) begin
            rv_d = 1'b0;
        end else if (state_d == S_DONE) begin
            rv_d = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            left_d[i] = '0;
            top_d[i]  = '0;
            skew_k    = cnt_d - CNT_W'(i);
            if ((state_d == S_FEED) && (cnt_d >= CNT_W'(i)) && (skew_k < CNT_W'(N))) begin
                left_d[i] = a_q[i][skew_k[ROW_W-1:0]];
                top_d[i]  = b_q[skew_k[ROW_W-1:0]][i];
            end
        end
    end

    assign seq_if.busy         = !idle;
    assign seq_if.done         = done_q;
    assign seq_if.result_valid = rv_q;
    assign seq_if.wr_err       = wr_err_q;
    assign seq_if.acc_rst      = acc_rst_q;
    assign seq_if.acc_en       = acc_en_q;
    assign seq_if.shift_en     = acc_en_q;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_flat
            assign seq_if.in_left_flat[gi*DW +: DW] = left_q[gi];
            assign seq_if.in_top_flat[gi*DW +: DW]  = top_q[gi];
        end
    endgenerate
endmodule
